// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the sequential RV64 core.
// Steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB,
// runs the imem/dmem request/ready handshakes with a bounded wait, pulses the
// IR/PC/register-file enables and arbitrates the register-file write port
// between writeback and the external debug/loader write path.
//
// Optional feature: define SEQ_PERF_CNT_EN to build the instret/cycles
// performance counters; otherwise both ports are tied to zero.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16  // max ready-wait cycles, 2..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic [6:0]  opcode,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        wsel,
  input  logic        ext_wr_req,
  output logic        ext_wr_grant,
  output logic        retire,
  output logic [2:0]  state,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret,
  output logic [31:0] cycles
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StTrap   = 3'd7;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  // Wait-counter value at which a still-missing ready means timeout.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] trap_q, trap_d;
  logic       opcode_legal;
  logic [2:0] retire_next;

  // Classify the opcode held in IR against the supported instruction classes.
  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  // Halt is honoured only at an instruction boundary.
  assign retire_next = halt_req ? StIdle : StFetch;

  // Next-state, wait-counter and trap-cause logic plus all decoded enables.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    trap_d       = trap_q;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    wsel         = 1'b0;
    retire       = 1'b0;
    ext_wr_grant = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d = StTrap;
          trap_d  = CauseTimeout;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        if (opcode_legal) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
          trap_d  = CauseIllegal;
        end
      end
      StExec: begin
        if (Branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken;
          retire   = 1'b1;
          state_d  = retire_next;
        end else if (MemRead || MemWrite) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = MemWrite;
        if (dmem_ready) begin
          if (MemWrite) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = retire_next;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StTrap;
          trap_d  = CauseTimeout;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = retire_next;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Every state change starts a fresh handshake window.
    if (state_d != state_q) wait_d = '0;

    // Writeback owns the port in WB; the external path gets it everywhere else.
    if (ext_wr_req && (state_q != StWb)) begin
      ext_wr_grant = 1'b1;
      reg_write    = 1'b1;
      wsel         = 1'b1;
    end
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      trap_q  <= CauseNone;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

  assign state      = state_q;
  assign trap_cause = trap_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret_q;
  logic [31:0] cycles_q;

  // Retired-instruction and active-cycle counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (retire) instret_q <= instret_q + 32'd1;
      if ((state_q >= StFetch) && (state_q <= StWb)) cycles_q <= cycles_q + 32'd1;
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`else
  assign instret = '0;
  assign cycles  = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Each instruction is described
// at a high level (opcode, fetch/mem wait counts, taken, halt) and expanded
// into a per-cycle trace of inputs and expected outputs, which one loop
// drives and compares. Segment-level literal checks pin latencies and counts.
module tb_multicycle_sequencer;

  localparam int unsigned TO = 4;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpLd  = 7'b0000011;
  localparam logic [6:0] OpSt  = 7'b0100011;
  localparam logic [6:0] OpBr  = 7'b1100011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBad = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, Branch, MemRead, MemWrite, branch_taken;
  logic [6:0]  opcode;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic        ir_write, pc_write, pc_src, reg_write, wsel;
  logic        ext_wr_req, ext_wr_grant, retire;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  logic [31:0] instret, cycles;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .opcode(opcode),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wsel(wsel), .ext_wr_req(ext_wr_req),
    .ext_wr_grant(ext_wr_grant), .retire(retire), .state(state),
    .trap_cause(trap_cause), .instret(instret), .cycles(cycles)
  );

  typedef struct {
    logic       chk, rst, start, halt, br, mr, mw, bt, iready, dready, ext;
    logic [6:0] op;
    logic [2:0] st;
    logic [1:0] tc;
    logic       imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_src;
    logic       reg_write, wsel, grant, retire;
  } cyc_t;

  cyc_t trace[$];

  // Current-instruction context used when expanding the trace.
  logic [6:0] cur_op = 7'd0;
  logic       cur_br = 0, cur_mr = 0, cur_mw = 0, cur_bt = 0, cur_halt = 0;
  logic [1:0] cur_tc = 2'b00;
  int         ext_left = 0;

  int tests = 0, fails = 0;
  int m_instret = 0, m_cycles = 0;
  int seg_active, seg_retire, seg_regwr, seg_dmem, seg_pcsrc, seg_grant;

  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t new_cyc(input logic [2:0] st);
    cyc_t c;
    c.chk = 1; c.rst = 0; c.start = 0; c.halt = cur_halt;
    c.br = cur_br; c.mr = cur_mr; c.mw = cur_mw; c.bt = cur_bt;
    c.iready = 0; c.dready = 0; c.ext = 0; c.op = cur_op;
    c.st = st; c.tc = cur_tc;
    c.imem_req = 0; c.ir_write = 0; c.dmem_req = 0; c.dmem_we = 0; c.pc_write = 0;
    c.pc_src = 0; c.reg_write = 0; c.wsel = 0; c.grant = 0; c.retire = 0;
    return c;
  endfunction

  // External write rule: granted whenever requested outside WB.
  task automatic push(input cyc_t c);
    cyc_t d = c;
    if (ext_left > 0) begin
      d.ext = 1;
      ext_left--;
    end
    if (d.ext && d.st != 3'd5) begin
      d.grant = 1; d.reg_write = 1; d.wsel = 1;
    end
    trace.push_back(d);
  endtask

  task automatic gen_reset();
    cyc_t c = new_cyc(3'd0);
    c.rst = 1; c.chk = 0;
    cur_tc = 2'b00;
    push(c);
  endtask

  task automatic gen_idle(input int n, input bit start_last);
    for (int i = 0; i < n; i++) begin
      cyc_t c = new_cyc(3'd0);
      if (start_last && i == n - 1) c.start = 1;
      push(c);
    end
  endtask

  task automatic gen_trap(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_t c = new_cyc(3'd7);
      c.start = 1;  // must be ignored
      push(c);
    end
  endtask

  task automatic set_op(input logic [6:0] op);
    cur_op = op;
    cur_br = (op == OpBr);
    cur_mr = (op == OpLd);
    cur_mw = (op == OpSt);
  endtask

  // fw/mw are wait cycles before ready; a value >= TO means ready never comes.
  task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input bit taken,
                           input bit halt, input bit ext_wb);
    cyc_t c;
    set_op(op);
    cur_bt = taken;
    cur_halt = halt;
    for (int i = 0; i < fw && i < TO; i++) begin
      c = new_cyc(3'd1); c.imem_req = 1; push(c);
    end
    if (fw >= TO) begin
      cur_tc = 2'b10;
      return;
    end
    c = new_cyc(3'd1); c.iready = 1; c.imem_req = 1; c.ir_write = 1; push(c);
    c = new_cyc(3'd2); c.start = 1; push(c);
    if (!(op inside {OpR, OpLd, OpSt, OpBr, OpI})) begin
      cur_tc = 2'b01;
      return;
    end
    c = new_cyc(3'd3);
    if (cur_br) begin
      c.pc_write = 1; c.pc_src = taken; c.retire = 1;
      push(c);
      return;
    end
    push(c);
    if (cur_mr || cur_mw) begin
      for (int i = 0; i < mw && i < TO; i++) begin
        c = new_cyc(3'd4); c.dmem_req = 1; c.dmem_we = cur_mw; push(c);
      end
      if (mw >= TO) begin
        cur_tc = 2'b10;
        return;
      end
      c = new_cyc(3'd4); c.dready = 1; c.dmem_req = 1; c.dmem_we = cur_mw;
      if (cur_mw) begin
        c.pc_write = 1; c.retire = 1;
        push(c);
        return;
      end
      push(c);
    end
    if (ext_wb) ext_left = 2;
    c = new_cyc(3'd5); c.reg_write = 1; c.pc_write = 1; c.retire = 1;
    push(c);
  endtask

  task automatic seg_clear();
    seg_active = 0; seg_retire = 0; seg_regwr = 0; seg_dmem = 0; seg_pcsrc = 0; seg_grant = 0;
  endtask

  task automatic run_trace();
    cyc_t c;
    while (trace.size() > 0) begin
      c = trace.pop_front();
      @(posedge clk);
      #1;
      reset = c.rst; start = c.start; halt_req = c.halt; opcode = c.op;
      Branch = c.br; MemRead = c.mr; MemWrite = c.mw; branch_taken = c.bt;
      imem_ready = c.iready; dmem_ready = c.dready; ext_wr_req = c.ext;
      @(negedge clk);
      if (c.chk) begin
        chk1("state", 32'(state), 32'(c.st));
        chk1("trap_cause", 32'(trap_cause), 32'(c.tc));
        chk1("imem_req", 32'(imem_req), 32'(c.imem_req));
        chk1("ir_write", 32'(ir_write), 32'(c.ir_write));
        chk1("dmem_req", 32'(dmem_req), 32'(c.dmem_req));
        if (c.dmem_req) chk1("dmem_we", 32'(dmem_we), 32'(c.dmem_we));
        chk1("pc_write", 32'(pc_write), 32'(c.pc_write));
        if (c.pc_write) chk1("pc_src", 32'(pc_src), 32'(c.pc_src));
        chk1("reg_write", 32'(reg_write), 32'(c.reg_write));
        chk1("wsel", 32'(wsel), 32'(c.wsel));
        chk1("ext_wr_grant", 32'(ext_wr_grant), 32'(c.grant));
        chk1("retire", 32'(retire), 32'(c.retire));
`ifdef SEQ_PERF_CNT_EN
        chk1("instret", instret, 32'(m_instret));
        chk1("cycles", cycles, 32'(m_cycles));
`else
        chk1("instret", instret, 32'd0);
        chk1("cycles", cycles, 32'd0);
`endif
        if (state >= 3'd1 && state <= 3'd5) seg_active++;
        if (retire) seg_retire++;
        if (reg_write) seg_regwr++;
        if (dmem_req) seg_dmem++;
        if (pc_write && pc_src) seg_pcsrc++;
        if (ext_wr_grant) seg_grant++;
      end
      if (c.rst) begin
        m_instret = 0; m_cycles = 0;
      end else begin
        if (c.st >= 3'd1 && c.st <= 3'd5) m_cycles++;
        if (c.retire) m_instret++;
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; halt_req = 0; opcode = '0; Branch = 0; MemRead = 0; MemWrite = 0;
    branch_taken = 0; imem_ready = 0; dmem_ready = 0; ext_wr_req = 0;

    // R-type, zero wait, halt at retire.
    seg_clear();
    gen_reset(); gen_idle(2, 1); gen_instr(OpR, 0, 0, 0, 1, 0); gen_idle(1, 0);
    run_trace();
    chk1("r_latency", 32'(seg_active), 32'd4);
    chk1("r_retires", 32'(seg_retire), 32'd1);
    chk1("r_regwr", 32'(seg_regwr), 32'd1);
`ifdef SEQ_PERF_CNT_EN
    chk1("r_instret_lit", instret, 32'd1);
    chk1("r_cycles_lit", cycles, 32'd4);
`endif

    // Load with three dmem wait cycles.
    seg_clear();
    gen_idle(1, 1); gen_instr(OpLd, 0, 3, 0, 1, 0); gen_idle(1, 0);
    run_trace();
    chk1("ld_latency", 32'(seg_active), 32'd8);
    chk1("ld_dmem_cycles", 32'(seg_dmem), 32'd4);

    // Taken branch.
    seg_clear();
    gen_idle(1, 1); gen_instr(OpBr, 0, 0, 1, 1, 0); gen_idle(1, 0);
    run_trace();
    chk1("br_latency", 32'(seg_active), 32'd3);
    chk1("br_regwr", 32'(seg_regwr), 32'd0);
    chk1("br_pcsrc", 32'(seg_pcsrc), 32'd1);

    // Back-to-back: store, I-ALU with ready on the last allowed fetch cycle and
    // ext write during WB, then untaken branch with halt.
    seg_clear();
    gen_idle(1, 1);
    gen_instr(OpSt, 0, 0, 0, 0, 0);
    gen_instr(OpI, 3, 0, 0, 0, 1);
    gen_instr(OpBr, 0, 0, 0, 1, 0);
    gen_idle(2, 0);
    run_trace();
    chk1("chain_latency", 32'(seg_active), 32'd14);
    chk1("chain_retires", 32'(seg_retire), 32'd3);
    chk1("chain_grants", 32'(seg_grant), 32'd1);
    chk1("chain_regwr", 32'(seg_regwr), 32'd2);

    // Ext write in IDLE, illegal opcode trap, ext write in TRAP.
    seg_clear();
    ext_left = 1; gen_idle(1, 0); gen_idle(1, 1);
    gen_instr(OpBad, 0, 0, 0, 0, 0);
    gen_trap(1); ext_left = 1; gen_trap(2);
    run_trace();
    chk1("ill_active", 32'(seg_active), 32'd2);
    chk1("ill_grants", 32'(seg_grant), 32'd2);
    chk1("ill_cause_lit", 32'(trap_cause), 32'd1);

    // Reset out of TRAP, then fetch timeout.
    seg_clear();
    gen_reset(); gen_idle(2, 1); gen_instr(OpR, TO, 0, 0, 0, 0); gen_trap(2);
    run_trace();
    chk1("fto_fetch_cycles", 32'(seg_active), 32'(TO));
    chk1("fto_cause_lit", 32'(trap_cause), 32'd2);

    // Data-memory timeout on a load.
    seg_clear();
    gen_reset(); gen_idle(1, 1); gen_instr(OpLd, 0, TO, 0, 0, 0); gen_trap(2);
    run_trace();
    chk1("mto_active", 32'(seg_active), 32'd7);
    chk1("mto_dmem_cycles", 32'(seg_dmem), 32'(TO));

    // Reset mid-MEM with dmem_ready arriving in the reset cycle.
    begin
      cyc_t c;
      gen_reset(); gen_idle(1, 1);
      set_op(OpLd); cur_bt = 0; cur_halt = 0;
      c = new_cyc(3'd1); c.iready = 1; c.imem_req = 1; c.ir_write = 1; push(c);
      c = new_cyc(3'd2); push(c);
      c = new_cyc(3'd3); push(c);
      c = new_cyc(3'd4); c.dmem_req = 1; push(c);
      c = new_cyc(3'd4); c.rst = 1; c.chk = 0; c.dready = 1; push(c);
      set_op(7'd0);
      gen_idle(2, 0);
    end
    run_trace();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
